// File: rtl/led_seq_ctrl.sv
// Four-LED display sequencer: prescaled or single-step advance over CHASE, BOUNCE,
// BLINK and FILL patterns, with every output registered on a single clock.
module led_seq_ctrl #(
  parameter int PRESCALE = 25_000_000,
  parameter int CNT_W    = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dir,
  input  logic [1:0] mode,
  input  logic       run,
  input  logic       step,
  output logic [3:0] leds,
  output logic [1:0] pos,
  output logic       tick
);

  typedef enum logic [1:0] {
    M_CHASE  = 2'b00,
    M_BOUNCE = 2'b01,
    M_BLINK  = 2'b10,
    M_FILL   = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  mode_e            mode_q, mode_d, mode_in_s;
  logic [1:0]       pos_q, pos_d, pos_entry_s;
  logic [3:0]       leds_q, leds_d;
  logic             bdir_q, bdir_d;
  logic             phase_q, phase_d;
  logic             step_q;
  logic             tick_q;
  logic             adv_s;

  function automatic logic [3:0] onehot(input logic [1:0] p);
    return 4'b0001 << p;
  endfunction

  // Fill grows from LED0 upward when d=1, from LED3 downward when d=0.
  function automatic logic [3:0] fill_pat(input logic [1:0] p, input logic d);
    logic [3:0] r;
    if (d) begin
      r = (4'b0010 << p) - 4'b0001;
    end else begin
      r = ~((4'b0001 << p) - 4'b0001);
    end
    return r;
  endfunction

  function automatic logic [1:0] next_pos(input logic [1:0] p, input logic d);
    logic [1:0] r;
    if (d) begin
      r = p + 2'd1;
    end else begin
      r = p - 2'd1;
    end
    return r;
  endfunction

  assign mode_in_s   = mode_e'(mode);
  assign pos_entry_s = dir ? 2'd0 : 2'd3;
  assign adv_s       = (run & (cnt_q == CNT_LAST)) | (~run & step & ~step_q);

  always_comb begin
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    pos_d   = pos_q;
    leds_d  = leds_q;
    bdir_d  = bdir_q;
    phase_d = phase_q;

    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    if (!adv_s) begin
      pos_d = pos_q;
    end else if (mode_in_s != mode_q) begin
      // A mode switch only restarts the new pattern; it never also steps it.
      mode_d  = mode_in_s;
      phase_d = 1'b0;
      bdir_d  = dir;
      pos_d   = pos_entry_s;
      case (mode_in_s)
        M_CHASE:  leds_d = onehot(pos_entry_s);
        M_BOUNCE: leds_d = onehot(pos_entry_s);
        M_BLINK:  leds_d = 4'b1111;
        M_FILL:   leds_d = fill_pat(pos_entry_s, dir);
        default:  leds_d = 4'b0001;
      endcase
    end else begin
      case (mode_q)
        M_CHASE: begin
          pos_d  = next_pos(pos_q, dir);
          leds_d = onehot(next_pos(pos_q, dir));
        end
        M_BOUNCE: begin
          if (bdir_q && (pos_q == 2'd3)) begin
            bdir_d = 1'b0;
            pos_d  = 2'd2;
          end else if (!bdir_q && (pos_q == 2'd0)) begin
            bdir_d = 1'b1;
            pos_d  = 2'd1;
          end else begin
            pos_d  = next_pos(pos_q, bdir_q);
          end
          leds_d = onehot(pos_d);
        end
        M_BLINK: begin
          phase_d = ~phase_q;
          leds_d  = phase_q ? 4'b1111 : 4'b0000;
        end
        M_FILL: begin
          pos_d  = next_pos(pos_q, dir);
          leds_d = fill_pat(next_pos(pos_q, dir), dir);
        end
        default: begin
          pos_d  = pos_q;
          leds_d = leds_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      mode_q  <= M_CHASE;
      pos_q   <= 2'd0;
      leds_q  <= 4'b0001;
      bdir_q  <= 1'b1;
      phase_q <= 1'b0;
      step_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      pos_q   <= pos_d;
      leds_q  <= leds_d;
      bdir_q  <= bdir_d;
      phase_q <= phase_d;
      step_q  <= step;
      tick_q  <= adv_s;
    end
  end

  assign leds = leds_q;
  assign pos  = pos_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: directed scenarios plus randomized traffic against
// a behavioural model of the sequencing rules.
module tb_led_seq_ctrl;
  localparam int PRESCALE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dir = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] leds;
  logic [1:0] pos;
  logic       tick;

  int checks = 0;
  int failures = 0;

  int         m_cnt, m_mode, m_pos, m_bdir;
  bit         m_stepq, m_phase, m_tick;
  logic [3:0] m_leds;

  always #5 clk = ~clk;

  led_seq_ctrl #(.PRESCALE(PRESCALE), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .dir(dir), .mode(mode), .run(run), .step(step),
    .leds(leds), .pos(pos), .tick(tick)
  );

  function automatic logic [3:0] pattern(int md, int p, bit d, bit ph);
    logic [3:0] r;
    r = 4'b0000;
    case (md)
      0, 1:    r[p] = 1'b1;
      2:       r = ph ? 4'b0000 : 4'b1111;
      default: for (int i = 0; i < 4; i++) if (d ? (i <= p) : (i >= p)) r[i] = 1'b1;
    endcase
    return r;
  endfunction

  // Advance the model on the current inputs, then clock the DUT and settle.
  task automatic cyc();
    bit adv;
    if (rst) begin
      m_cnt = 0; m_mode = 0; m_pos = 0; m_bdir = 1; m_stepq = 0;
      m_phase = 0; m_tick = 0; m_leds = 4'b0001;
    end else begin
      adv = run ? (m_cnt == PRESCALE - 1) : (step && !m_stepq);
      m_cnt = run ? (m_cnt + 1) % PRESCALE : 0;
      m_stepq = step;
      m_tick = adv;
      if (adv) begin
        if (int'(mode) != m_mode) begin
          m_mode = int'(mode); m_phase = 0;
          m_bdir = dir ? 1 : -1;
          m_pos = dir ? 0 : 3;
        end else if (m_mode == 1) begin
          if (m_pos + m_bdir < 0 || m_pos + m_bdir > 3) m_bdir = -m_bdir;
          m_pos = m_pos + m_bdir;
        end else if (m_mode == 2) begin
          m_phase = !m_phase;
        end else begin
          m_pos = (m_pos + (dir ? 1 : 3)) % 4;
        end
        m_leds = pattern(m_mode, m_pos, dir, m_phase);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      cyc();
      if (tick === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; step = 1'b0; mode = 2'b00; dir = 1'b1;
    cyc(); cyc();
    checks++; if (leds !== 4'b0001) begin failures++; $display("FAIL reset_leds got=%b exp=0001", leds); end
    checks++; if (pos !== 2'd0) begin failures++; $display("FAIL reset_pos got=%0d exp=0", pos); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
  endtask

  task automatic test_chase();
    logic [3:0] exp_seq [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    int first = -1;
    int nt = 0;
    rst = 1'b1; run = 1'b1; mode = 2'b00; dir = 1'b1;
    cyc();
    rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      checks++; if (leds !== m_leds || pos !== 2'(m_pos) || tick !== m_tick) begin
        failures++; $display("FAIL chase_model c=%0d got=%b/%0d/%b exp=%b/%0d/%b", c, leds, pos, tick, m_leds, m_pos, m_tick);
      end
      if (tick === 1'b1) begin
        if (first < 0) first = c;
        if (nt < 5) begin
          checks++; if (leds !== exp_seq[nt]) begin failures++; $display("FAIL chase_seq n=%0d got=%b exp=%b", nt, leds, exp_seq[nt]); end
        end
        nt++;
      end
    end
    checks++; if (first != 4) begin failures++; $display("FAIL chase_first_tick got=%0d exp=4", first); end
    checks++; if (nt != 5) begin failures++; $display("FAIL chase_tick_count got=%0d exp=5", nt); end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    bit ok;
    mode = 2'b01; dir = 1'b1; run = 1'b1;
    wait_tick(8, ok);
    checks++; if (!ok || leds !== 4'b0001) begin failures++; $display("FAIL bounce_entry got=%b ok=%0d exp=0001", leds, ok); end
    for (int k = 0; k < 7; k++) begin
      wait_tick(8, ok);
      checks++; if (!ok || leds !== exp_seq[k] || leds !== m_leds) begin
        failures++; $display("FAIL bounce_seq k=%0d got=%b ok=%0d exp=%b", k, leds, ok, exp_seq[k]);
      end
    end
  endtask

  task automatic test_step();
    int nt = 0;
    step = 1'b1;
    cyc();
    run = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (tick === 1'b1) nt++;
    end
    checks++; if (nt != 0) begin failures++; $display("FAIL step_held got=%0d exp=0", nt); end
    step = 1'b0;
    cyc(); cyc();
    for (int p = 0; p < 2; p++) begin
      step = 1'b1;
      cyc();
      checks++; if (tick !== 1'b1 || leds !== m_leds) begin failures++; $display("FAIL step_pulse p=%0d tick=%b leds=%b exp=1/%b", p, tick, leds, m_leds); end
      if (tick === 1'b1) nt++;
      step = 1'b0;
      cyc();
      if (tick === 1'b1) nt++;
      cyc(); cyc();
      if (tick === 1'b1) nt++;
    end
    checks++; if (nt != 2) begin failures++; $display("FAIL step_count got=%0d exp=2", nt); end
  endtask

  task automatic test_mode_mid();
    logic [3:0] held;
    bit ok;
    int c;
    mode = 2'b00; dir = 1'b1; run = 1'b1;
    wait_tick(8, ok);
    checks++; if (!ok || leds !== 4'b0001) begin failures++; $display("FAIL mid_chase_entry got=%b exp=0001", leds); end
    cyc();
    held = leds;
    mode = 2'b10;
    c = 0;
    while (tick !== 1'b1 && c < 8) begin
      checks++; if (leds !== held) begin failures++; $display("FAIL mid_hold got=%b exp=%b", leds, held); end
      cyc();
      c++;
    end
    checks++; if (tick !== 1'b1 || leds !== 4'b1111) begin failures++; $display("FAIL mid_blink_entry got=%b tick=%b exp=1111", leds, tick); end
    wait_tick(8, ok);
    checks++; if (!ok || leds !== 4'b0000) begin failures++; $display("FAIL mid_blink_off got=%b exp=0000", leds); end
    wait_tick(8, ok);
    checks++; if (!ok || leds !== 4'b1111) begin failures++; $display("FAIL mid_blink_on got=%b exp=1111", leds); end
  endtask

  task automatic test_fill_reset();
    logic [3:0] exp_seq [5] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b1000};
    bit ok;
    mode = 2'b11; dir = 1'b0; run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_tick(8, ok);
      checks++; if (!ok || leds !== exp_seq[k]) begin failures++; $display("FAIL fill_seq k=%0d got=%b exp=%b", k, leds, exp_seq[k]); end
    end
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    checks++; if (leds !== 4'b0001 || pos !== 2'd0 || tick !== 1'b0) begin
      failures++; $display("FAIL fill_midreset got=%b/%0d/%b exp=0001/0/0", leds, pos, tick);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) run = ~run;
      step = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      cyc();
      checks++; if (leds !== m_leds || pos !== 2'(m_pos) || tick !== m_tick) begin
        failures++; $display("FAIL random c=%0d got=%b/%0d/%b exp=%b/%0d/%b", c, leds, pos, tick, m_leds, m_pos, m_tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_chase();
    test_bounce();
    test_step();
    test_mode_mid();
    test_fill_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
